keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
Front-panel input stage feeding the CPU control block. It scans a 4x4 active-low hex keypad and accumulates pressed digits into a 16-bit entry value, presented as user_input/input_valid. It debounces the raw front-panel command buttons into single-cycle pulses, which drive the control block's b_* inputs. The entry is cleared automatically once a command has consumed it.

Parameters:
SCAN_DIV, 1000, clocks each keypad column is driven; rows are sampled on the last clock of the column period.
DEBOUNCE_SCANS, 4, consecutive full scans needed to accept a press or a release.
NUM_BTN, 12, number of command buttons.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
col_n  output  4  keypad column drive, active-low, one column low at a time
row_n  input  4  keypad row sense, active-low, asynchronous (externally pulled up)
btn_n  input  NUM_BTN  raw command buttons, active-low, asynchronous
btn_pulse  output  NUM_BTN  one-cycle pulse per accepted button press
user_input  output  16  accumulated hex entry
input_valid  output  1  high when at least one digit has been entered
digit_count  output  3  digits entered, saturates at 4 (for the display)

Behaviour:
- Reset (async, rst=1) values:
  - col_n=4'b1110; btn_pulse=0; user_input=0; input_valid=0; digit_count=0.
  - Scan counter, column index, key FSM and all debounce counters are cleared.
  - Synchronizer flops reset to "released" (all ones).
- Synchronization: row_n and btn_n each pass through a 2-flop synchronizer before any use.
- Scanner:
  - A column tick fires every SCAN_DIV clocks; on each tick the column index advances 0->1->2->3->0.
  - col_n drives the current column low.
  - On the last clock of each column period, the synchronized rows are latched into a 16-bit scan image. Key code = row*4 + col, giving 0x0-0xF.
  - A scan_done strobe fires when column 3's sample is taken, once every 4*SCAN_DIV clocks.
- Key classification at scan_done:
  - Exactly one bit set -> single key K.
  - Zero bits -> none.
  - Two or more bits -> none (multi-key chords are ignored).
- Key FSM, evaluated only at scan_done, using a counter cnt:
  - IDLE: single key K -> CAND with cand=K, cnt=1.
  - CAND:
    - Same K: cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED and emit digit cand.
    - Different single key -> restart CAND with the new key, cnt=1.
    - None -> IDLE.
  - PRESSED: any scan result other than cand -> REL with cnt=1; otherwise stay.
  - REL:
    - Result other than cand: cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE.
    - Result equals cand -> PRESSED.
  - Exactly one digit is emitted per accepted press; holding a key never repeats.
- Digit emit timing: the digit is written on the clock after the qualifying scan_done.
  - user_input <= {user_input[11:0], digit}.
  - digit_count <= min(digit_count+1, 4).
  - A fifth or later digit keeps shifting; the oldest digit drops out.
- input_valid = (digit_count != 0), registered.
- Button debounce, per button:
  - Counter advances on scan_done while the synchronized level differs from the debounced level.
  - The counter resets to 0 whenever the levels match.
  - At DEBOUNCE_SCANS, the debounced level flips.
  - A debounced press edge (released->pressed) gives btn_pulse[i]=1 for exactly one clk.
  - Release produces no pulse.
  - Several buttons may pulse in the same cycle.
- Entry consumption: user_input holds its value during the pulse cycle, so the consumer sees it. If any btn_pulse bit is 1 in cycle N, then in cycle N+1: user_input=0, digit_count=0, input_valid=0.
- Simultaneous clear and digit emit in the same cycle: clear wins and the digit is discarded.
- Reset mid-press: all state returns to IDLE. A key still held after rst deasserts is treated as a new press and is accepted after DEBOUNCE_SCANS scans.

Decomposition:
- Shared package keypad_pkg:
  - Button index constants: BTN_STEP=0, BTN_RESET=1, BTN_RUNHALT=2, BTN_STOREINC=3, BTN_IRQ=4, BTN_DEC=5, BTN_LOAD=6, BTN_TOA=7, BTN_TOSP=8, BTN_TOX=9, BTN_TOY=10, BTN_TOPC=11.
  - Key FSM state encoding: IDLE, CAND, PRESSED, REL.
  - KEY_ROWS=4, KEY_COLS=4, MAX_DIGITS=4.
- One sub-module, button_debounce: synchronizer, counter and press pulse. It is instantiated NUM_BTN times with a generate loop and reuses the existing edge_detect for the pulse.
- The scanner and the key FSM stay inline.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2):
1. Hold row 2/col 2 for 4 scans -> one digit: user_input=0x000A, input_valid=1, digit_count=1; continued holding adds nothing.
2. Press and release keys 1,2,3,4,5 in sequence -> user_input=0x2345, digit_count=4.
3. Hold keys 0x3 and 0x5 together for 6 scans -> no change to user_input or digit_count.
4. Toggle key 0x7 every scan for 5 scans, then hold steady for 3 scans -> exactly one digit 0x7 is accepted.
5. Enter 0x1234, then press btn_n[6] cleanly -> btn_pulse=0x040 for one cycle with user_input=0x1234; next cycle user_input=0, input_valid=0. A bouncing button produces exactly one pulse.
6. Assert rst while key 0x9 is in PRESSED -> all outputs 0 immediately and col_n=4'b1110. Keep the key held after release of rst -> digit 0x9 accepted after 2 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the front-panel keypad entry block: button indices,
// key FSM states and helpers for decoding one scan of the 4x4 keypad.
package keypad_pkg;

   localparam int KEY_ROWS   = 4;
   localparam int KEY_COLS   = 4;
   localparam int MAX_DIGITS = 4;

   localparam int BTN_STEP     = 0;
   localparam int BTN_RESET    = 1;
   localparam int BTN_RUNHALT  = 2;
   localparam int BTN_STOREINC = 3;
   localparam int BTN_IRQ      = 4;
   localparam int BTN_DEC      = 5;
   localparam int BTN_LOAD     = 6;
   localparam int BTN_TOA      = 7;
   localparam int BTN_TOSP     = 8;
   localparam int BTN_TOX      = 9;
   localparam int BTN_TOY      = 10;
   localparam int BTN_TOPC     = 11;

   typedef enum logic [1:0] {
      IDLE,
      CAND,
      PRESSED,
      REL
   } keyState_e;

   // A scan image names a key only when exactly one bit is set; chords and
   // empty scans are both treated as "no key".
   function automatic logic isSingleKey(input logic [15:0] image);
      return (image != 16'h0000) && ((image & (image - 16'h0001)) == 16'h0000);
   endfunction

   // Bit position of the set bit; only meaningful for single-key images.
   function automatic logic [3:0] keyCode(input logic [15:0] image);
      logic [3:0] code;
      code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (image[i]) code = 4'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One front-panel command button: synchronize the raw active-low level,
// debounce it against keypad scan strobes, and pulse once per accepted press.
module button_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic scanDone,
   input  logic btnRaw,
   output logic pulse
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic          btnMeta;
   logic          btnSync;
   logic          pressedLevel;
   logic [CW-1:0] bounceCnt;
   logic          syncPressed;

   assign syncPressed = ~btnSync;

   // Two-flop synchronizer for the asynchronous button line. Both flops come
   // out of reset at the released level so a reset never fakes a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btnMeta <= 1'b1;
         btnSync <= 1'b1;
      end else begin
         btnMeta <= btnRaw;
         btnSync <= btnMeta;
      end
   end

   // The debounced level only moves after the synchronized level has
   // disagreed with it on enough consecutive scan strobes. Any agreement in
   // between throws the partial count away, so contact bounce never adds up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pressedLevel <= 1'b0;
         bounceCnt    <= '0;
      end else if (syncPressed == pressedLevel) begin
         bounceCnt <= '0;
      end else if (scanDone) begin
         if (bounceCnt == CW'(DEBOUNCE_SCANS - 1)) begin
            pressedLevel <= syncPressed;
            bounceCnt    <= '0;
         end else begin
            bounceCnt <= bounceCnt + CW'(1);
         end
      end
   end

   edge_detect uEdge (
      .clk  (clk),
      .rst  (rst),
      .sig  (pressedLevel),
      .rise (pulse)
   );

endmodule

// File: rtl/edge_detect.sv
// Registered rising-edge detector: one-clock pulse when sig goes 0 -> 1.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sigPrev;

   // Remember last cycle's level and flag a 0->1 transition for exactly one
   // clock; the pulse is registered so consumers see a clean glitch-free strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sigPrev <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sigPrev <= sig;
         rise    <= sig & ~sigPrev;
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// Front-panel input stage: scans the hex keypad into a 16-bit entry and turns
// the raw command buttons into one-cycle pulses that also consume the entry.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int NUM_BTN        = 12
) (
   input  logic               clk,
   input  logic               rst,
   output logic [3:0]         col_n,
   input  logic [3:0]         row_n,
   input  logic [NUM_BTN-1:0] btn_n,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic [15:0]        user_input,
   output logic               input_valid,
   output logic [2:0]         digit_count
);

   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]     rowMeta;
   logic [3:0]     rowSync;
   logic [SCW-1:0] scanCnt;
   logic [1:0]     colIdx;
   logic           colTick;
   logic [15:0]    scanImage;
   logic           scanDone;

   keyState_e      keyState;
   logic [3:0]     candKey;
   logic [CW-1:0]  keyCnt;
   logic           emitValid;
   logic [3:0]     emitDigit;

   logic           resSingle;
   logic [3:0]     resKey;
   logic           resIsCand;
   logic           clearEntry;

   assign colTick    = (scanCnt == SCW'(SCAN_DIV - 1));
   assign col_n      = ~(4'b0001 << colIdx);
   assign resSingle  = isSingleKey(scanImage);
   assign resKey     = keyCode(scanImage);
   assign resIsCand  = resSingle && (resKey == candKey);
   assign clearEntry = |btn_pulse;

   // Column scanner. Each column is driven for SCAN_DIV clocks; the rows are
   // sampled on the last clock of that window so the synchronizer has long
   // since settled. Key code is row*4+col, so each column owns bits col,
   // col+4, col+8, col+12 of the image. The scan strobe is raised the clock
   // after column 3 is sampled, so the image it qualifies is complete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rowMeta   <= 4'hF;
         rowSync   <= 4'hF;
         scanCnt   <= '0;
         colIdx    <= 2'd0;
         scanImage <= 16'h0000;
         scanDone  <= 1'b0;
      end else begin
         rowMeta  <= row_n;
         rowSync  <= rowMeta;
         scanDone <= colTick && (colIdx == 2'd3);
         if (colTick) begin
            scanCnt <= '0;
            colIdx  <= colIdx + 2'd1;
            for (int r = 0; r < KEY_ROWS; r++) begin
               scanImage[r*KEY_COLS + int'(colIdx)] <= ~rowSync[r];
            end
         end else begin
            scanCnt <= scanCnt + SCW'(1);
         end
      end
   end

   // Key FSM, advanced once per full scan. A candidate must be seen on
   // DEBOUNCE_SCANS consecutive scans before its digit is emitted, and must
   // then be absent for as many scans before another press is considered,
   // so a held key emits exactly once. A single brief dropout while pressed
   // returns to PRESSED without a second emit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         keyState  <= IDLE;
         candKey   <= 4'h0;
         keyCnt    <= '0;
         emitValid <= 1'b0;
         emitDigit <= 4'h0;
      end else begin
         emitValid <= 1'b0;
         if (scanDone) begin
            case (keyState)
               IDLE: begin
                  if (resSingle) begin
                     keyState <= CAND;
                     candKey  <= resKey;
                     keyCnt   <= CW'(1);
                  end
               end
               CAND: begin
                  if (resIsCand) begin
                     keyCnt <= keyCnt + CW'(1);
                     if (keyCnt == CW'(DEBOUNCE_SCANS - 1)) begin
                        keyState  <= PRESSED;
                        emitValid <= 1'b1;
                        emitDigit <= candKey;
                     end
                  end else if (resSingle) begin
                     candKey <= resKey;
                     keyCnt  <= CW'(1);
                  end else begin
                     keyState <= IDLE;
                  end
               end
               PRESSED: begin
                  if (!resIsCand) begin
                     keyState <= REL;
                     keyCnt   <= CW'(1);
                  end
               end
               REL: begin
                  if (resIsCand) begin
                     keyState <= PRESSED;
                  end else if (keyCnt == CW'(DEBOUNCE_SCANS - 1)) begin
                     keyState <= IDLE;
                  end else begin
                     keyCnt <= keyCnt + CW'(1);
                  end
               end
               default: keyState <= IDLE;
            endcase
         end
      end
   end

   // Entry register. A command pulse means the control block has just read
   // the entry, so it is wiped on the following clock; that clear takes
   // priority over a digit arriving on the same clock. Digits shift in from
   // the right and the count saturates at the display width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         user_input  <= 16'h0000;
         digit_count <= 3'd0;
         input_valid <= 1'b0;
      end else if (clearEntry) begin
         user_input  <= 16'h0000;
         digit_count <= 3'd0;
         input_valid <= 1'b0;
      end else if (emitValid) begin
         user_input  <= {user_input[11:0], emitDigit};
         input_valid <= 1'b1;
         if (digit_count < 3'(MAX_DIGITS)) begin
            digit_count <= digit_count + 3'd1;
         end
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : gBtn
      button_debounce #(
         .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
      ) uDebounce (
         .clk      (clk),
         .rst      (rst),
         .scanDone (scanDone),
         .btnRaw   (btn_n[i]),
         .pulse    (btn_pulse[i])
      );
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 keypad model; uses a
// short scan period and two-scan debounce so every scenario runs quickly.
module tb_keypad_entry;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_SCANS = 2;
   localparam int NUM_BTN        = 12;
   localparam int SCAN           = 4 * SCAN_DIV;

   logic               clk;
   logic               rst;
   logic [3:0]         col_n;
   logic [3:0]         row_n;
   logic [NUM_BTN-1:0] btn_n;
   logic [NUM_BTN-1:0] btn_pulse;
   logic [15:0]        user_input;
   logic               input_valid;
   logic [2:0]         digit_count;

   logic [15:0]        heldKeys;
   int                 checks;
   int                 failures;

   keypad_entry #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .NUM_BTN        (NUM_BTN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_n       (col_n),
      .row_n       (row_n),
      .btn_n       (btn_n),
      .btn_pulse   (btn_pulse),
      .user_input  (user_input),
      .input_valid (input_valid),
      .digit_count (digit_count)
   );

   // 100 MHz system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix model: a held key (row*4+col) pulls its row low while its
   // column is being driven low.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         row_n[r] = ~|(heldKeys[r*4 +: 4] & ~col_n);
      end
   end

   // Hard ceiling so the run can never hang.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys, input logic [NUM_BTN-1:0] btns,
                                input int cycles);
      heldKeys = keys;
      btn_n    = ~btns;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic enterDigit(input int key);
      logic [15:0] mask;
      mask = 16'h0001 << key;
      applyStimulus(mask, '0, 4 * SCAN);
      applyStimulus(16'h0000, '0, 4 * SCAN);
   endtask

   // Scenario sequence; expected values are worked out by hand from the
   // shift-in entry behaviour, starting from reset.
   initial begin
      int  pulseCount;
      logic found;

      checks   = 0;
      failures = 0;
      heldKeys = 16'h0000;
      btn_n    = '1;
      rst      = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("rstColN", 32'(col_n), 32'h0000000E);
      checkOutput("rstUserInput", 32'(user_input), 32'h0);
      checkOutput("rstValid", 32'(input_valid), 32'h0);
      checkOutput("rstCount", 32'(digit_count), 32'h0);
      checkOutput("rstPulse", 32'(btn_pulse), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] single key 0xA held");
      applyStimulus(16'h0400, '0, 4 * SCAN);
      checkOutput("holdAUserInput", 32'(user_input), 32'h000A);
      checkOutput("holdAValid", 32'(input_valid), 32'h1);
      checkOutput("holdACount", 32'(digit_count), 32'h1);
      applyStimulus(16'h0400, '0, 4 * SCAN);
      checkOutput("holdANoRepeat", 32'(user_input), 32'h000A);
      checkOutput("holdANoRepeatCount", 32'(digit_count), 32'h1);
      applyStimulus(16'h0000, '0, 4 * SCAN);

      $display("[TB] keys 1..5 in sequence");
      for (int k = 1; k <= 5; k++) enterDigit(k);
      checkOutput("seqUserInput", 32'(user_input), 32'h2345);
      checkOutput("seqCountSat", 32'(digit_count), 32'h4);

      $display("[TB] chord 0x3+0x5");
      applyStimulus(16'h0028, '0, 6 * SCAN);
      applyStimulus(16'h0000, '0, 4 * SCAN);
      checkOutput("chordUserInput", 32'(user_input), 32'h2345);
      checkOutput("chordCount", 32'(digit_count), 32'h4);

      $display("[TB] toggling key 0x7");
      for (int s = 0; s < 5; s++) begin
         applyStimulus((s % 2 == 0) ? 16'h0080 : 16'h0000, '0, SCAN);
      end
      checkOutput("toggleNoDigit", 32'(user_input), 32'h2345);
      applyStimulus(16'h0080, '0, 3 * SCAN);
      applyStimulus(16'h0000, '0, 4 * SCAN);
      checkOutput("toggleOneDigit", 32'(user_input), 32'h3457);

      $display("[TB] command button consumes entry");
      for (int k = 1; k <= 4; k++) enterDigit(k);
      checkOutput("preCmdUserInput", 32'(user_input), 32'h1234);
      heldKeys = 16'h0000;
      btn_n    = ~(12'h040);
      found    = 1'b0;
      for (int i = 0; i < 8 * SCAN && !found; i++) begin
         @(negedge clk);
         if (btn_pulse != '0) found = 1'b1;
      end
      checkOutput("cmdPulseSeen", 32'(found), 32'h1);
      checkOutput("cmdPulseValue", 32'(btn_pulse), 32'h040);
      checkOutput("cmdHoldsEntry", 32'(user_input), 32'h1234);
      @(negedge clk);
      checkOutput("cmdPulseOneCycle", 32'(btn_pulse), 32'h0);
      checkOutput("cmdClearUserInput", 32'(user_input), 32'h0);
      checkOutput("cmdClearValid", 32'(input_valid), 32'h0);
      checkOutput("cmdClearCount", 32'(digit_count), 32'h0);
      btn_n = '1;
      repeat (6 * SCAN) @(negedge clk);

      $display("[TB] bouncing button 3");
      pulseCount = 0;
      for (int i = 0; i < 42; i++) begin
         if (i % 3 == 0) btn_n[3] = ~btn_n[3];
         @(negedge clk);
         if (btn_pulse[3]) pulseCount++;
      end
      btn_n[3] = 1'b0;
      for (int i = 0; i < 6 * SCAN; i++) begin
         @(negedge clk);
         if (btn_pulse[3]) pulseCount++;
      end
      btn_n[3] = 1'b1;
      for (int i = 0; i < 6 * SCAN; i++) begin
         @(negedge clk);
         if (btn_pulse[3]) pulseCount++;
      end
      checkOutput("bouncePulseCount", 32'(pulseCount), 32'h1);

      $display("[TB] reset while key 0x9 pressed");
      applyStimulus(16'h0200, '0, 4 * SCAN);
      checkOutput("preRstUserInput", 32'(user_input), 32'h0009);
      rst = 1'b1;
      #1;
      checkOutput("midRstUserInput", 32'(user_input), 32'h0);
      checkOutput("midRstValid", 32'(input_valid), 32'h0);
      checkOutput("midRstCount", 32'(digit_count), 32'h0);
      checkOutput("midRstColN", 32'(col_n), 32'h0000000E);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("postRstNotYet", 32'(input_valid), 32'h0);
      found = 1'b0;
      for (int i = 0; i < 5 * SCAN && !found; i++) begin
         @(negedge clk);
         if (input_valid) found = 1'b1;
      end
      checkOutput("postRstAccepted", 32'(found), 32'h1);
      checkOutput("postRstUserInput", 32'(user_input), 32'h0009);
      checkOutput("postRstCount", 32'(digit_count), 32'h1);
      applyStimulus(16'h0000, '0, 4 * SCAN);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
